// File: rtl/wb_matvec_engine.sv
// wb_matvec_engine
//   Wishbone slave holding a ROWS x COLS matrix A and a COLS vector x in
//   local registers. It computes y = A*x with one multiply-accumulate per
//   cycle. Software drives it with START, polls BUSY/DONE, or waits for irq_o.
//   Operands can be signed or unsigned, and results can optionally saturate
//   to the element range.
//
//   Address map (byte address, [11:10] region, [9:2] index):
//     0x000 CTRL   : b0 START (write-1, reads 0), b1 SIGNED, b2 SAT, b3 IRQ_EN
//     0x004 STATUS : b0 BUSY (RO), b1 DONE (W1C), b2 ERR (W1C)
//     0x400 A[i]   : row-major, i = r*COLS + c
//     0x800 x[i]
//     0xC00 y[i]   : read-only results
//
// Ports
//   wb_clk_i / wb_rst_i    : bus clock, async active-high reset
//   wbs_cyc_i .. wbs_dat_i : Wishbone slave request (sel[0] gates writes)
//   wbs_ack_o / wbs_dat_o  : registered single-cycle ack with read data
//   irq_o                  : DONE & IRQ_EN
module wb_matvec_engine #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(COLS)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int NELEM = ROWS * COLS;
  localparam int AIW   = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int RW    = (ROWS > 1)  ? $clog2(ROWS)  : 1;
  localparam int CW    = (COLS > 1)  ? $clog2(COLS)  : 1;

  // Saturation bounds, held in 33 bits so every 32-bit accumulator value
  // compares correctly in both modes.
  localparam logic signed [32:0] SMAX = 33'((2**(WIDTH-1)) - 1);
  localparam logic signed [32:0] SMIN = -SMAX - 33'sd1;
  localparam logic        [32:0] UMAX = 33'((2**WIDTH) - 1);

  typedef enum logic {IDLE, RUN} state_e;
  state_e state, state_nxt;

  logic [WIDTH-1:0] mat_a [NELEM];
  logic [WIDTH-1:0] vec_x [COLS];
  logic [31:0]      vec_y [ROWS];

  logic                 ctrl_signed, ctrl_sat, ctrl_irq_en;
  logic                 run_signed, run_sat;
  logic                 done, err;
  logic [RW-1:0]        r_cnt;
  logic [CW-1:0]        c_cnt;
  logic [AIW-1:0]       a_ptr;
  logic [ACC_WIDTH-1:0] acc;

  // ---------------- bus decode ----------------
  logic [1:0] region;
  logic [7:0] idx;
  logic       bus_req, wr_en, busy;
  logic       wr_ctrl, wr_status, wr_a, wr_x;
  logic       a_hit, x_hit, y_hit;
  logic       start_go, busy_err, c_last, r_last, finish;

  assign region    = wbs_adr_i[11:10];
  assign idx       = wbs_adr_i[9:2];
  // The ~ack term keeps one request from being seen twice while the master
  // is still holding cyc/stb during the ack cycle.
  assign bus_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_en     = bus_req & wbs_we_i & wbs_sel_i[0];
  assign busy      = (state == RUN);

  assign wr_ctrl   = wr_en && region == 2'b00 && idx == 8'd0;
  assign wr_status = wr_en && region == 2'b00 && idx == 8'd1;
  assign wr_a      = wr_en && region == 2'b01;
  assign wr_x      = wr_en && region == 2'b10;

  assign a_hit     = int'(idx) < NELEM;
  assign x_hit     = int'(idx) < COLS;
  assign y_hit     = int'(idx) < ROWS;

  assign start_go  = wr_ctrl & wbs_dat_i[0] & ~busy;
  // Any A/x write, or START, during a run is rejected and flagged.
  assign busy_err  = busy & ((wr_ctrl & wbs_dat_i[0]) | wr_a | wr_x);

  assign c_last    = (c_cnt == CW'(COLS - 1));
  assign r_last    = (r_cnt == RW'(ROWS - 1));
  assign finish    = busy & c_last & r_last;

  assign irq_o     = done & ctrl_irq_en;

  // ---------------- MAC datapath ----------------
  logic        [WIDTH-1:0]     a_el, x_el;
  logic signed [2*WIDTH-1:0]   prod_s;
  logic        [2*WIDTH-1:0]   prod_u;
  logic        [ACC_WIDTH-1:0] prod_ext, sum;
  logic signed [32:0]          sum_s;
  logic        [32:0]          sum_u;
  logic        [31:0]          y_post;

  assign a_el     = mat_a[a_ptr];
  assign x_el     = vec_x[c_cnt];
  assign prod_s   = $signed(a_el) * $signed(x_el);
  assign prod_u   = a_el * x_el;
  assign prod_ext = run_signed ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);
  assign sum      = acc + prod_ext;
  assign sum_s    = 33'($signed(sum));
  assign sum_u    = 33'(sum);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case can leave it unassigned and infer a latch.
  always_comb begin
    y_post = '0;
    if (run_signed) begin
      y_post = sum_s[31:0];
      if (run_sat && sum_s > SMAX) y_post = SMAX[31:0];
      if (run_sat && sum_s < SMIN) y_post = SMIN[31:0];
    end else begin
      y_post = sum_u[31:0];
      if (run_sat && sum_u > UMAX) y_post = UMAX[31:0];
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (c_last && r_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so that every flop samples
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt      <= '0;
      c_cnt      <= '0;
      a_ptr      <= '0;
      acc        <= '0;
      run_signed <= 1'b0;
      run_sat    <= 1'b0;
    end else if (start_go) begin
      r_cnt      <= '0;
      c_cnt      <= '0;
      a_ptr      <= '0;
      acc        <= '0;
      run_signed <= wbs_dat_i[1];
      run_sat    <= wbs_dat_i[2];
    end else if (busy) begin
      a_ptr <= a_ptr + 1'b1;
      if (c_last) begin
        acc   <= '0;
        c_cnt <= '0;
        r_cnt <= r_last ? '0 : r_cnt + 1'b1;
      end else begin
        acc   <= sum;
        c_cnt <= c_cnt + 1'b1;
      end
    end
  end

  // ---------------- registers, buffers, bus response ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_signed <= 1'b0;
      ctrl_sat    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_signed <= wbs_dat_i[1];
        ctrl_sat    <= wbs_dat_i[2];
        ctrl_irq_en <= wbs_dat_i[3];
      end
      // Hardware set wins over a software W1C landing on the same edge.
      if (finish)                          done <= 1'b1;
      else if (start_go)                   done <= 1'b0;
      else if (wr_status && wbs_dat_i[1])  done <= 1'b0;
      if (busy_err)                        err  <= 1'b1;
      else if (wr_status && wbs_dat_i[2])  err  <= 1'b0;
    end
  end

  // NOTE: the operand and result buffers are cleared by reset because
  // software may read them back before ever writing them.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NELEM; i++) mat_a[i] <= '0;
      for (int i = 0; i < COLS; i++)  vec_x[i] <= '0;
      for (int i = 0; i < ROWS; i++)  vec_y[i] <= '0;
    end else begin
      if (wr_a && a_hit && !busy) mat_a[idx[AIW-1:0]] <= wbs_dat_i[WIDTH-1:0];
      if (wr_x && x_hit && !busy) vec_x[idx[CW-1:0]]  <= wbs_dat_i[WIDTH-1:0];
      if (busy && c_last)         vec_y[r_cnt]        <= y_post;
    end
  end

  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (region)
      2'b00: begin
        if (idx == 8'd0)      rd_data = {28'd0, ctrl_irq_en, ctrl_sat, ctrl_signed, 1'b0};
        else if (idx == 8'd1) rd_data = {29'd0, err, done, busy};
      end
      2'b01:   if (a_hit) rd_data = 32'(mat_a[idx[AIW-1:0]]);
      2'b10:   if (x_hit) rd_data = 32'(vec_x[idx[CW-1:0]]);
      default: if (y_hit) rd_data = vec_y[idx[RW-1:0]];
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= bus_req;
      wbs_dat_o <= (bus_req && !wbs_we_i) ? rd_data : '0;
    end
  end

  // Address, lane and data bits this slave never decodes.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:12], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i};

endmodule
